// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - WIDTH            datapath width (only 32 is supported)
//   - SEL_*            opcode constants, same encoding as the ALU sel input
//   - seq_state_e      sequencer FSM states
//   - result_t         captured result (Y plus four flags)
//   - is_alu_op()      opcode implemented by the downstream ALU
//   - forced_result()  result returned for opcodes nobody implements
//   - mul_result()     result derived from a 64-bit multiplier product
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_NOT  = 4'b0010;
  localparam logic [3:0] SEL_NOR  = 4'b0011;
  localparam logic [3:0] SEL_XOR  = 4'b0100;
  localparam logic [3:0] SEL_NAND = 4'b0101;
  localparam logic [3:0] SEL_ADD  = 4'b0110;
  localparam logic [3:0] SEL_SUB  = 4'b0111;
  localparam logic [3:0] SEL_SUB2 = 4'b1000;
  localparam logic [3:0] SEL_MUL  = 4'b1001;
  localparam logic [3:0] SEL_SHL  = 4'b1010;
  localparam logic [3:0] SEL_ASL  = 4'b1011;
  localparam logic [3:0] SEL_SHR  = 4'b1100;
  localparam logic [3:0] SEL_ASR  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             negative;
    logic             zero;
    logic             overflow;
  } result_t;

  // The ALU implements everything up to ASR except the multiply slot.
  function automatic logic is_alu_op(input logic [3:0] sel);
    return (sel <= SEL_ASR) && (sel != SEL_MUL);
  endfunction

  function automatic result_t forced_result();
    result_t r;
    r      = '0;
    r.zero = 1'b1;
    return r;
  endfunction

  // Low half is the result; any bit set in the high half means the
  // product did not fit, reported on both cout and overflow.
  function automatic result_t mul_result(input logic [2*WIDTH-1:0] p);
    result_t r;
    r.y        = p[WIDTH-1:0];
    r.cout     = |p[2*WIDTH-1:WIDTH];
    r.overflow = |p[2*WIDTH-1:WIDTH];
    r.negative = p[WIDTH-1];
    r.zero     = (p[WIDTH-1:0] == '0);
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer_if
// Bundles the three buses of the sequencer:
//   command in : in_valid, in_ready, in_sel, in_a, in_b, in_cin
//   ALU side   : alu_a, alu_b, alu_sel, alu_cin (to ALU),
//                alu_y, alu_cout, alu_negative, alu_zero, alu_overflow (from ALU)
//   result out : out_valid, out_ready, out_y, out_cout, out_negative,
//                out_zero, out_overflow
//   status     : busy
// Modports:
//   slave  - the sequencer itself
//   master - the environment (command source, ALU, result sink)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holds valid and its payload stable until that edge;
// ready may depend combinationally on the state but never on valid.
// -----------------------------------------------------------------------------
interface alu_cmd_sequencer_if;
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sel;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_overflow;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_cout;
  logic             out_negative;
  logic             out_zero;
  logic             out_overflow;

  logic             busy;

  modport slave (
    input  in_valid, in_sel, in_a, in_b, in_cin,
    output in_ready,
    output alu_a, alu_b, alu_sel, alu_cin,
    input  alu_y, alu_cout, alu_negative, alu_zero, alu_overflow,
    output out_valid, out_y, out_cout, out_negative, out_zero, out_overflow,
    input  out_ready,
    output busy
  );

  modport master (
    output in_valid, in_sel, in_a, in_b, in_cin,
    input  in_ready,
    input  alu_a, alu_b, alu_sel, alu_cin,
    output alu_y, alu_cout, alu_negative, alu_zero, alu_overflow,
    input  out_valid, out_y, out_cout, out_negative, out_zero, out_overflow,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/alu_seq_mul.sv
// -----------------------------------------------------------------------------
// alu_seq_mul
// Unsigned WIDTH x WIDTH shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_start    one-cycle pulse; loads i_a / i_b and starts 32 iterations
//   i_a, i_b   multiplicand / multiplier, sampled with i_start
//   o_done     high during the last (32nd) iteration cycle
//   o_product  product including the current iteration; final when o_done=1
// Only built when ALU_SEQ_MUL_EN is defined.
// -----------------------------------------------------------------------------
module alu_seq_mul
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam logic [5:0] LAST_ITER = 6'd31;

  logic                 r_run;
  logic [5:0]           r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_acc_next;

  // Add the shifted multiplicand whenever the current multiplier bit is set.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 6'd1;
      if (r_cnt == LAST_ITER) begin
        r_run <= 1'b0;
      end
    end
  end

  // The caller captures the product in the same cycle done is high, so the
  // last partial sum is presented combinationally instead of a cycle later.
  assign o_done    = r_run && (r_cnt == LAST_ITER);
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Command front end for the 32-bit combinational ALU. Accepts one command at a
// time, registers operands onto the ALU inputs, captures Y and flags one cycle
// later and holds the result until the sink takes it. Opcode SEL_MUL is run
// locally as a 32-cycle shift-add when ALU_SEQ_MUL_EN is defined; otherwise it
// is treated like the other unsupported opcodes (forced zero result).
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   bus          alu_cmd_sequencer_if.slave (command, ALU and result buses)
//   o_dbg_state  current FSM state
// Configuration macro: ALU_SEQ_MUL_EN (defined = multiplier compiled in).
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus,
  output seq_state_e           o_dbg_state
);

  seq_state_e        r_state;
  seq_state_e        w_state_next;
  seq_state_e        w_dispatch;
  logic              r_forced;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_alu;

  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic [3:0]        r_alu_sel;
  logic              r_alu_cin;
  result_t           r_out;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_is_alu = is_alu_op(bus.in_sel);

`ifdef ALU_SEQ_MUL_EN
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;

  assign w_is_mul    = (bus.in_sel == SEL_MUL);
  assign w_mul_start = w_accept & w_is_mul;

  alu_seq_mul u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (bus.in_a),
    .i_b       (bus.in_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`else
  assign w_is_mul = 1'b0;
`endif

  // Where an accepted command goes; shared by IDLE and the DONE fast path.
  assign w_dispatch = w_is_mul ? ST_MUL : ST_EXEC;

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = w_dispatch;
        end
      end
      ST_EXEC: begin
        w_state_next = ST_DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        // Consuming the result frees the slot in the same cycle.
        if (bus.out_ready) begin
          w_in_ready   = 1'b1;
          w_state_next = bus.in_valid ? w_dispatch : ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_forced  <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_alu_cin <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_forced <= !w_is_alu && !w_is_mul;
        // Only real ALU commands touch the ALU inputs; they otherwise keep
        // the previous command's values.
        if (w_is_alu) begin
          r_alu_a   <= bus.in_a;
          r_alu_b   <= bus.in_b;
          r_alu_sel <= bus.in_sel;
          r_alu_cin <= bus.in_cin;
        end
      end

      if (r_state == ST_EXEC) begin
        if (r_forced) begin
          r_out <= forced_result();
        end else begin
          r_out.y        <= bus.alu_y;
          r_out.cout     <= bus.alu_cout;
          r_out.negative <= bus.alu_negative;
          r_out.zero     <= bus.alu_zero;
          r_out.overflow <= bus.alu_overflow;
        end
      end

`ifdef ALU_SEQ_MUL_EN
      if ((r_state == ST_MUL) && w_mul_done) begin
        r_out <= mul_result(w_mul_product);
      end
`endif
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_sel      = r_alu_sel;
  assign bus.alu_cin      = r_alu_cin;
  assign bus.out_valid    = (r_state == ST_DONE);
  assign bus.out_y        = r_out.y;
  assign bus.out_cout     = r_out.cout;
  assign bus.out_negative = r_out.negative;
  assign bus.out_zero     = r_out.zero;
  assign bus.out_overflow = r_out.overflow;
  assign bus.busy         = (r_state != ST_IDLE);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer with a behavioural 32-bit ALU attached
// to the ALU side of the interface. Expected results are hand-computed in the
// vector table; a few sequences cover back-pressure and reset mid-command.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if ifc ();
  seq_state_e dbg_state;

  alu_cmd_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .o_dbg_state (dbg_state)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  // ---------------- behavioural ALU ----------------
  logic [32:0] alu_t;
  logic        alu_v;
  always_comb begin
    alu_t = '0;
    alu_v = 1'b0;
    case (ifc.alu_sel)
      SEL_AND:  alu_t = {1'b0, ifc.alu_a & ifc.alu_b};
      SEL_OR:   alu_t = {1'b0, ifc.alu_a | ifc.alu_b};
      SEL_NOT:  alu_t = {1'b0, ~ifc.alu_a};
      SEL_NOR:  alu_t = {1'b0, ~(ifc.alu_a | ifc.alu_b)};
      SEL_XOR:  alu_t = {1'b0, ifc.alu_a ^ ifc.alu_b};
      SEL_NAND: alu_t = {1'b0, ~(ifc.alu_a & ifc.alu_b)};
      SEL_ADD: begin
        alu_t = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b} + {32'b0, ifc.alu_cin};
        alu_v = (ifc.alu_a[31] == ifc.alu_b[31]) && (alu_t[31] != ifc.alu_a[31]);
      end
      SEL_SUB: begin
        alu_t = {1'b0, ifc.alu_a} + {1'b0, ~ifc.alu_b} + 33'd1;
        alu_v = (ifc.alu_a[31] != ifc.alu_b[31]) && (alu_t[31] != ifc.alu_a[31]);
      end
      SEL_SUB2: begin
        alu_t = {1'b0, ifc.alu_b} + {1'b0, ~ifc.alu_a} + 33'd1;
        alu_v = (ifc.alu_a[31] != ifc.alu_b[31]) && (alu_t[31] != ifc.alu_b[31]);
      end
      SEL_SHL, SEL_ASL: alu_t = {1'b0, ifc.alu_a << ifc.alu_b[4:0]};
      SEL_SHR:  alu_t = {1'b0, ifc.alu_a >> ifc.alu_b[4:0]};
      SEL_ASR:  alu_t = {1'b0, $unsigned($signed(ifc.alu_a) >>> ifc.alu_b[4:0])};
      default:  alu_t = '0;
    endcase
    ifc.alu_y        = alu_t[31:0];
    ifc.alu_cout     = alu_t[32];
    ifc.alu_negative = alu_t[31];
    ifc.alu_zero     = (alu_t[31:0] == 32'd0);
    ifc.alu_overflow = alu_v;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];
  logic [3:0]  m_alu_sel;
  logic [31:0] m_alu_a;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] y;
    logic [3:0]  f;   // {cout, negative, zero, overflow}
    int          lat;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [3:0] sel, input logic [31:0] a,
                              input logic [31:0] b, input logic cin,
                              input logic [31:0] y, input logic [3:0] f,
                              input int lat);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.cin = cin;
    v.y = y; v.f = f; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_cmd(input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
    int w;
    ifc.in_valid = 1'b1;
    ifc.in_sel   = sel;
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_cin   = cin;
    w = 0;
    while (!ifc.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) check("accept_timeout", 64'(w), 64'd0);
    @(posedge clk);
    if (is_alu_op(sel)) begin
      m_alu_sel = sel;
      m_alu_a   = a;
    end
    #1;
    ifc.in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge (cycle T+1).
  task automatic wait_result(input string name, input int exp_lat);
    int n;
    logic [36:0] e;
    n = 1;
    check({name, "_alu_sel"}, 64'(ifc.alu_sel), 64'(m_alu_sel));
    check({name, "_alu_a"}, 64'(ifc.alu_a), 64'(m_alu_a));
    while (!ifc.out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
    check({name, "_result"},
          64'({ifc.out_y, ifc.out_cout, ifc.out_negative, ifc.out_zero, ifc.out_overflow}),
          64'(e));
  endtask

  task automatic consume(input string name);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    check({name, "_valid_after"}, 64'(ifc.out_valid), 64'd0);
    check({name, "_ready_after"}, 64'(ifc.in_ready), 64'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk(SEL_ADD,  32'd5,        32'd3,        1'b0, 32'd8,        4'b0000, 2);
    vecs[1]  = mk(SEL_SUB,  32'd3,        32'd3,        1'b0, 32'd0,        4'b1010, 2);
    vecs[2]  = mk(SEL_ADD,  32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 4'b0101, 2);
    vecs[3]  = mk(SEL_AND,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 4'b0100, 2);
    vecs[4]  = mk(SEL_XOR,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0,        4'b0010, 2);
    vecs[5]  = mk(SEL_ADD,  32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        4'b1010, 2);
    vecs[6]  = mk(SEL_ADD,  32'd1,        32'd1,        1'b1, 32'd3,        4'b0000, 2);
    vecs[7]  = mk(SEL_SHL,  32'd1,        32'd4,        1'b0, 32'h10,       4'b0000, 2);
    vecs[8]  = mk(SEL_SUB2, 32'd3,        32'd10,       1'b0, 32'd7,        4'b1000, 2);
    vecs[9]  = mk(4'b1110,  32'h1234,     32'h5678,     1'b1, 32'd0,        4'b0010, 2);
    vecs[10] = mk(4'b1111,  32'hFFFF,     32'h1,        1'b0, 32'd0,        4'b0010, 2);
    vecs[11] = MUL_ON ? mk(SEL_MUL, 32'h00010000, 32'h00010000, 1'b0, 32'd0, 4'b1011, 33)
                      : mk(SEL_MUL, 32'h00010000, 32'h00010000, 1'b0, 32'd0, 4'b0010, 2);
    vecs[12] = MUL_ON ? mk(SEL_MUL, 32'd3, 32'd5, 1'b0, 32'd15, 4'b0000, 33)
                      : mk(SEL_MUL, 32'd3, 32'd5, 1'b0, 32'd0,  4'b0010, 2);
    vecs[13] = mk(SEL_ASR,  32'h80000000, 32'd4,        1'b0, 32'hF8000000, 4'b0100, 2);
    vecs[14] = mk(SEL_NOR,  32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 4'b0100, 2);
    vecs[15] = MUL_ON ? mk(SEL_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 4'b1001, 33)
                      : mk(SEL_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 4'b0010, 2);

    // Reset state
    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_sel = '0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_cin = 1'b0;
    ifc.out_ready = 1'b0;
    m_alu_sel = '0; m_alu_a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(ifc.in_ready),  64'd1);
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_busy",      64'(ifc.busy),      64'd0);
    check("rst_alu_a",     64'(ifc.alu_a),     64'd0);
    check("rst_out_y",     64'(ifc.out_y),     64'd0);
    check("rst_state",     64'(dbg_state),     64'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      send_cmd(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
      exp_q.push_back({vecs[i].y, vecs[i].f});
      check($sformatf("v%0d_busy", i), 64'(ifc.busy), 64'd1);
      wait_result($sformatf("v%0d", i), vecs[i].lat);
      consume($sformatf("v%0d", i));
    end

    // Back-pressure: hold out_ready low, then consume and accept together
    send_cmd(SEL_ADD, 32'd10, 32'd20, 1'b0);
    exp_q.push_back({32'd30, 4'b0000});
    wait_result("hold_first", 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_y", k),     64'(ifc.out_y),     64'd30);
      check($sformatf("hold%0d_valid", k), 64'(ifc.out_valid), 64'd1);
      check($sformatf("hold%0d_ready", k), 64'(ifc.in_ready),  64'd0);
    end
    ifc.in_valid = 1'b1; ifc.in_sel = SEL_SUB; ifc.in_a = 32'd9; ifc.in_b = 32'd4; ifc.in_cin = 1'b0;
    ifc.out_ready = 1'b1;
    #1;
    check("hold_release_ready", 64'(ifc.in_ready), 64'd1);
    exp_q.push_back({32'd5, 4'b1000});
    @(posedge clk);
    m_alu_sel = SEL_SUB; m_alu_a = 32'd9;
    #1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    check("hold_next_not_valid", 64'(ifc.out_valid), 64'd0);
    wait_result("hold_next", 2);
    consume("hold_next");

    // Reset in the middle of a multiply (iteration 10)
    send_cmd(SEL_MUL, 32'd3, 32'd5, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_alu_sel = '0; m_alu_a = '0;
    check("mrst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("mrst_busy",      64'(ifc.busy),      64'd0);
    check("mrst_in_ready",  64'(ifc.in_ready),  64'd1);
    check("mrst_alu",       64'({ifc.alu_a, ifc.alu_sel, ifc.alu_cin}), 64'd0);
    check("mrst_alu_b",     64'(ifc.alu_b),     64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mrst_stays_idle", 64'(ifc.out_valid), 64'd0);
    send_cmd(4'b1110, 32'h1234, 32'h1, 1'b1);
    exp_q.push_back({32'd0, 4'b0010});
    wait_result("mrst_forced", 2);
    consume("mrst_forced");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
